clk_div_ctrl: RTL and testbench

Configuration sequencer for the two-channel Clock_Divider. It accepts divide-ratio update requests over a valid/ready handshake and rejects a ratio of zero. Accepted updates run a fixed sequence: hold the divider in reset, load the new ratio, release, settle, acknowledge. This gives glitch-free reprogramming of `div1`/`div2` while the SHA1 core and display logic run off `clk1`/`clk2`.

---
 rtl/clk_div_ctrl_if.sv | 11 +
 rtl/clk_div_ctrl.sv | 134 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// Divide-ratio update request channel between a requester and clk_div_ctrl.
// The requester holds cfg_valid and its data stable until cfg_ready is seen.
interface clk_div_ctrl_if;
  logic       cfg_valid;
  logic       cfg_sel;
  logic [4:0] cfg_div;
  logic       cfg_ready;

  modport master (output cfg_valid, output cfg_sel, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_sel, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Sequencer that reprograms the two Clock_Divider ratios glitch-free:
// hold divider in reset, load ratio, release, settle, acknowledge.
//
// state     | meaning
// ST_POR    | post-reset hold of the divider for RST_CYCLES cycles
// ST_IDLE   | accepting requests; divider running
// ST_HOLD   | divider held in reset; new ratio loaded on first edge
// ST_SETTLE | divider released, waiting SETTLE_CYCLES before ack
// ST_ACK    | one-cycle done pulse
module clk_div_ctrl #(
  parameter logic [4:0] DIV1_INIT     = 5'd1,
  parameter logic [4:0] DIV2_INIT     = 5'd2,
  parameter int         RST_CYCLES    = 4,
  parameter int         SETTLE_CYCLES = 8
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  clk_div_ctrl_if.slave  cfg,
  output logic [4:0]     div1,
  output logic [4:0]     div2,
  output logic           div_rst,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam logic [7:0] RST_LD    = 8'(RST_CYCLES - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_POR,
    ST_IDLE,
    ST_HOLD,
    ST_SETTLE,
    ST_ACK
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic [4:0] val_q, val_d;
  logic [4:0] div1_q, div1_d;
  logic [4:0] div2_q, div2_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [4:0] cur_div;

  assign cur_div = cfg.cfg_sel ? div2_q : div1_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    val_d   = val_q;
    div1_d  = div1_q;
    div2_d  = div2_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_POR: begin
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          if (cfg.cfg_div == 5'd0) begin
            err_d = 1'b1;
          end else if (cfg.cfg_div == cur_div) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = RST_LD;
            sel_d   = cfg.cfg_sel;
            val_d   = cfg.cfg_div;
          end
        end
      end
      ST_HOLD: begin
        // RST_CYCLES >= 2, so cnt_q only equals RST_LD on the first HOLD edge
        if (cnt_q == RST_LD) begin
          if (sel_q) div2_d = val_q;
          else       div1_d = val_q;
        end
        if (cnt_q == 8'd0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_ACK;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_POR;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_POR;
      cnt_q   <= RST_LD;
      sel_q   <= 1'b0;
      val_q   <= 5'd0;
      div1_q  <= DIV1_INIT;
      div2_q  <= DIV2_INIT;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      div1_q  <= div1_d;
      div2_q  <= div2_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cfg.cfg_ready = (state_q == ST_IDLE);
  assign div_rst       = (state_q == ST_POR) || (state_q == ST_HOLD);
  assign busy          = (state_q != ST_IDLE);
  assign div1          = div1_q;
  assign div2          = div2_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: reset, updates, reject/no-op, held
// request and mid-update reset, with hand-computed cycle-by-cycle values.
module tb_clk_div_ctrl;

  logic       sys_clk;
  logic       sys_rst;
  logic [4:0] div1, div2;
  logic       div_rst, busy, done, err;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       seen_done;

  clk_div_ctrl_if cfg_if ();

  clk_div_ctrl dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cfg     (cfg_if),
    .div1    (div1),
    .div2    (div2),
    .div_rst (div_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic sel, input logic [4:0] val);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = sel;
    cfg_if.cfg_div   = val;
  endtask

  initial begin
    sys_rst          = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sel   = 1'b0;
    cfg_if.cfg_div   = 5'd0;

    // reset: 3 cycles, then POR for 4 cycles
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst div1", 32'(div1), 32'd1);
    check("rst div2", 32'(div2), 32'd2);
    check("rst div_rst", 32'(div_rst), 32'd1);
    check("rst busy", 32'(busy), 32'd1);
    check("rst ready", 32'(cfg_if.cfg_ready), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    sys_rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge sys_clk);
      check($sformatf("por div_rst c%0d", c), 32'(div_rst), 32'(c <= 4));
      check($sformatf("por ready c%0d", c), 32'(cfg_if.cfg_ready), 32'(c == 5));
      check($sformatf("por busy c%0d", c), 32'(busy), 32'(c <= 4));
    end

    // update div1 to 5
    drive_req(1'b0, 5'd5);
    @(negedge sys_clk);
    cfg_if.cfg_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) @(negedge sys_clk);
      check($sformatf("upd1 div_rst c%0d", c), 32'(div_rst), 32'(c <= 4));
      check($sformatf("upd1 div1 c%0d", c), 32'(div1), (c >= 2) ? 32'd5 : 32'd1);
      check($sformatf("upd1 div2 c%0d", c), 32'(div2), 32'd2);
      check($sformatf("upd1 done c%0d", c), 32'(done), 32'(c == 13));
      check($sformatf("upd1 ready c%0d", c), 32'(cfg_if.cfg_ready), 32'(c == 14));
    end

    // zero ratio rejected
    drive_req(1'b1, 5'd0);
    @(negedge sys_clk);
    cfg_if.cfg_valid = 1'b0;
    check("zero err c1", 32'(err), 32'd1);
    check("zero done c1", 32'(done), 32'd0);
    check("zero div2 c1", 32'(div2), 32'd2);
    check("zero div_rst c1", 32'(div_rst), 32'd0);
    check("zero busy c1", 32'(busy), 32'd0);
    check("zero ready c1", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge sys_clk);
    check("zero err c2", 32'(err), 32'd0);
    check("zero div_rst c2", 32'(div_rst), 32'd0);
    check("zero div2 c2", 32'(div2), 32'd2);

    // same value is a no-op acknowledge
    drive_req(1'b1, 5'd2);
    @(negedge sys_clk);
    cfg_if.cfg_valid = 1'b0;
    check("same done c1", 32'(done), 32'd1);
    check("same err c1", 32'(err), 32'd0);
    check("same div_rst c1", 32'(div_rst), 32'd0);
    check("same busy c1", 32'(busy), 32'd0);
    @(negedge sys_clk);
    check("same done c2", 32'(done), 32'd0);
    check("same div_rst c2", 32'(div_rst), 32'd0);

    // back-to-back reject then no-op on consecutive edges
    drive_req(1'b0, 5'd0);
    @(negedge sys_clk);
    check("b2b err c1", 32'(err), 32'd1);
    check("b2b ready c1", 32'(cfg_if.cfg_ready), 32'd1);
    drive_req(1'b0, 5'd5);
    @(negedge sys_clk);
    cfg_if.cfg_valid = 1'b0;
    check("b2b done c2", 32'(done), 32'd1);
    check("b2b err c2", 32'(err), 32'd0);
    check("b2b div1 c2", 32'(div1), 32'd5);

    // held request: div1 -> 9, then div2 -> 31 waits for ready
    drive_req(1'b0, 5'd9);
    @(negedge sys_clk);
    drive_req(1'b1, 5'd31);
    for (int c = 1; c <= 28; c++) begin
      if (c > 1) @(negedge sys_clk);
      if (c == 15) cfg_if.cfg_valid = 1'b0;
      if (c <= 14)
        check($sformatf("held ready c%0d", c), 32'(cfg_if.cfg_ready), 32'(c == 14));
      check($sformatf("held div1 c%0d", c), 32'(div1), (c >= 2) ? 32'd9 : 32'd5);
      check($sformatf("held div2 c%0d", c), 32'(div2), (c >= 16) ? 32'd31 : 32'd2);
      check($sformatf("held div_rst c%0d", c), 32'(div_rst),
            32'((c <= 4) || (c >= 15 && c <= 18)));
      check($sformatf("held done c%0d", c), 32'(done), 32'((c == 13) || (c == 27)));
    end
    check("held ready c28", 32'(cfg_if.cfg_ready), 32'd1);

    // reset in the third SETTLE cycle of a div1 -> 7 update
    drive_req(1'b0, 5'd7);
    @(negedge sys_clk);
    cfg_if.cfg_valid = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge sys_clk);
      seen_done |= done;
    end
    check("mid div1 c7", 32'(div1), 32'd7);
    check("mid busy c7", 32'(busy), 32'd1);
    check("mid div_rst c7", 32'(div_rst), 32'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("mid rst div1", 32'(div1), 32'd1);
    check("mid rst div2", 32'(div2), 32'd2);
    check("mid rst div_rst", 32'(div_rst), 32'd1);
    check("mid rst ready", 32'(cfg_if.cfg_ready), 32'd0);
    sys_rst = 1'b0;
    for (int c = 8; c <= 12; c++) begin
      if (c > 8) @(negedge sys_clk);
      seen_done |= done;
      check($sformatf("mid por div_rst c%0d", c), 32'(div_rst), 32'(c <= 11));
      check($sformatf("mid por ready c%0d", c), 32'(cfg_if.cfg_ready), 32'(c == 12));
      check($sformatf("mid por div1 c%0d", c), 32'(div1), 32'd1);
    end
    for (int c = 13; c <= 16; c++) begin
      @(negedge sys_clk);
      seen_done |= done;
    end
    check("mid no done", 32'(seen_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
